pq_deadline_dispatch: RTL
=========================

# pq_deadline_dispatch

Downstream consumer of the array priority queue. It keeps the system time base and watches the queue head, which is the minimum-`data` cell. When the head deadline has been reached, it pops the cell and delivers `{data, id}` plus its lateness to a valid/ready sink. The block also exports the current time so the upstream producer can compute absolute deadlines for pushes.

## Interface
- `TIME_WIDTH`, 24: width of the time counter, `cell_t.data` and `cell_t.id`.
- `PRESCALE`, 1: clock cycles per time unit. Must be ≥1. Prescaler counter width is `$clog2(PRESCALE)+1`.

- `clk_i` input 1: the single clock.
- `rst_i` input 1: synchronous, active-high reset.
- `enable_i` input 1: dispatch enable. When low, no pops occur. The time base keeps running.
- `time_o` output TIME_WIDTH: current time `now`, registered.
- `head_valid_i` input 1: queue is non-empty and the head fields are meaningful.
- `head_data_i` input TIME_WIDTH: head deadline (`cell_t.data`).
- `head_id_i` input TIME_WIDTH: head identifier (`cell_t.id`).
- `pop_o` output 1: single-cycle pop request to the queue.
- `out_valid_o` output 1: a dispatched event is held.
- `out_ready_i` input 1: the sink accepts the event.
- `out_data_o` output TIME_WIDTH: deadline of the dispatched event.
- `out_id_o` output TIME_WIDTH: id of the dispatched event.
- `out_late_o` output TIME_WIDTH: `now − deadline` (mod 2^TIME_WIDTH), sampled at pop.
- `dispatched_o` output 16: count of events accepted by the sink. Wraps at 2^16.

## Operation
- **Time base**
  - The prescaler counts 0..PRESCALE−1 and wraps.
  - `now` increments by 1 (mod 2^TIME_WIDTH) in the cycle the prescaler wraps.
  - With PRESCALE=1, `now` increments every cycle.
- **Expiry test**
  - `diff = now − head_data_i`, computed mod 2^TIME_WIDTH.
  - The head is expired when `diff[TIME_WIDTH−1] == 0`, i.e. the deadline lies within the half-range window at or before `now`.
  - A deadline exactly equal to `now` is expired.
  - The upstream producer guarantees that deadlines never exceed `now + 2^(TIME_WIDTH−1) − 1`.
- **State machine** (2 states)
  - CHECK:
    - `pop_o = enable_i & head_valid_i & expired`.
    - When `pop_o` is high, the output registers load `head_data_i`, `head_id_i` and `diff` into `out_data_o`, `out_id_o` and `out_late_o`, and the FSM goes to OUT.
    - Otherwise the FSM stays in CHECK.
  - OUT:
    - `out_valid_o = 1` and `pop_o = 0`.
    - On `out_valid_o & out_ready_i`, `dispatched_o` increments and the FSM returns to CHECK.
    - The out fields stay stable for as long as `out_valid_o` is high.
- The queue updates its head in the cycle after a pop. The mandatory ≥1 cycle in OUT guarantees the head is never re-evaluated while stale, so no double pops can occur.
- Expiry is computed from registered `now`, i.e. the value before any increment in the same cycle.
- **Reset values:**
  - `now = 0`, prescaler `= 0`, state `= CHECK`.
  - `pop_o = 0`, `out_valid_o = 0`.
  - `out_data_o`, `out_id_o`, `out_late_o`, `dispatched_o = 0`.
- **Reset while in OUT:** the held event is discarded. It has already been popped and is lost by design.
- **`enable_i` deasserted while in OUT:** the held event still completes its handshake. Only new pops are suppressed.
- **`head_valid_i` low:** no pop, regardless of `head_data_i`.

## Timing
- `pop_o` is combinational from registered state, registered `now` and the head inputs. It asserts in the cycle expiry is first visible.
- `out_valid_o` rises on the clock edge after `pop_o`. Pop-to-valid latency is 1 cycle.
- Minimum dispatch interval is 2 cycles per event: one CHECK cycle and one OUT cycle with `out_ready_i` high.
- `time_o` changes on the same edge that the prescaler wraps. For PRESCALE=N, the first increment occurs N cycles after reset release.
- No combinational path from `out_ready_i` to `pop_o`.

## Test plan
- **Reset values:** assert `rst_i` for 3 cycles with arbitrary inputs → every output reads 0, and `time_o` reads 0 on the first cycle after release.
- **Exact expiry:**
  - Setup: PRESCALE=1, `enable_i`=1, `out_ready_i`=1, head {data=5, id=7} valid from reset release.
  - Required: `pop_o` high only in the cycle `time_o`=5.
  - Required: next cycle `out_valid_o`=1 with `out_data_o`=5, `out_id_o`=7, `out_late_o`=0.
  - Required: `dispatched_o`=1 afterwards.
- **Late head:** head {data=3, id=2} first asserted at `now`=10 → immediate pop, and `out_late_o`=7.
- **Backpressure:**
  - Setup: `out_ready_i` low for 10 cycles while further expired heads are presented.
  - Required: `out_valid_o` held with stable fields and no additional `pop_o`.
  - Required: after `out_ready_i` rises, the next pop occurs no earlier than the following cycle.
- **Wrap-around:**
  - Setup: force `now`=0xFFFFF0.
  - Head data=0x000005 → no pop until `now` reaches 0x000005, and `out_late_o`=0.
  - Head data=0xFFFFE0 → immediate pop, and `out_late_o`=0x10.
- **Enable and prescale:**
  - With `enable_i`=0 and an expired head → no pop, and `time_o` keeps advancing.
  - With PRESCALE=4 → `time_o` increments every 4 cycles.
  - Re-enabling `enable_i` → pop in the same cycle.

Source files
------------

// File: rtl/pq_deadline_dispatch.sv
// Deadline dispatcher: keeps the system time base, pops the priority-queue head
// once its deadline is reached and hands {data, id, lateness} to a valid/ready sink.
module pq_deadline_dispatch #(
  parameter int unsigned TIME_WIDTH = 24,
  parameter int unsigned PRESCALE   = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  output logic [TIME_WIDTH-1:0] time_o,
  input  logic                  head_valid_i,
  input  logic [TIME_WIDTH-1:0] head_data_i,
  input  logic [TIME_WIDTH-1:0] head_id_i,
  output logic                  pop_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [TIME_WIDTH-1:0] out_data_o,
  output logic [TIME_WIDTH-1:0] out_id_o,
  output logic [TIME_WIDTH-1:0] out_late_o,
  output logic [15:0]           dispatched_o
);

  localparam int unsigned PsW = $clog2(PRESCALE) + 1;

  typedef enum logic {StCheck, StOut} state_e;

  state_e                r_state;
  logic [PsW-1:0]        r_presc;
  logic [TIME_WIDTH-1:0] r_now;
  logic [TIME_WIDTH-1:0] r_out_data;
  logic [TIME_WIDTH-1:0] r_out_id;
  logic [TIME_WIDTH-1:0] r_out_late;
  logic [15:0]           r_dispatched;
  logic                  r_out_valid;

  logic                  w_wrap;
  logic [TIME_WIDTH-1:0] w_diff;
  logic                  w_expired;
  logic                  w_pop;

  assign w_wrap = (r_presc == PsW'(PRESCALE - 1));

  // Modular distance to the deadline; MSB clear means the deadline is at or behind now.
  assign w_diff    = r_now - head_data_i;
  assign w_expired = ~w_diff[TIME_WIDTH-1];

  // Pop is gated by reset so the queue never sees a request while we are being cleared.
  assign w_pop = ~rst_i & enable_i & head_valid_i & w_expired & (r_state == StCheck);

  // Time base: prescaler wraps every PRESCALE cycles and advances now on that edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_presc <= '0;
      r_now   <= '0;
    end else if (w_wrap) begin
      r_presc <= '0;
      r_now   <= r_now + TIME_WIDTH'(1);
    end else begin
      r_presc <= r_presc + PsW'(1);
    end
  end

  // Dispatch FSM: capture the head on pop, hold it until the sink takes it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= StCheck;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_id     <= '0;
      r_out_late   <= '0;
      r_dispatched <= '0;
    end else begin
      unique case (r_state)
        StCheck: begin
          if (w_pop) begin
            r_out_data  <= head_data_i;
            r_out_id    <= head_id_i;
            r_out_late  <= w_diff;
            r_out_valid <= 1'b1;
            r_state     <= StOut;
          end
        end
        StOut: begin
          // Handshake completes regardless of enable_i; only new pops are suppressed.
          if (out_ready_i) begin
            r_dispatched <= r_dispatched + 16'd1;
            r_out_valid  <= 1'b0;
            r_state      <= StCheck;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= StCheck;
        end
      endcase
    end
  end

  assign time_o       = r_now;
  assign pop_o        = w_pop;
  assign out_valid_o  = r_out_valid;
  assign out_data_o   = r_out_data;
  assign out_id_o     = r_out_id;
  assign out_late_o   = r_out_late;
  assign dispatched_o = r_dispatched;

endmodule
